vec_ex_sequencer: RTL and testbench

VEC_EX_SEQUENCER -- requirements
Module: vec_ex_sequencer

---
 rtl/vec_ex_sequencer.sv | 164 ++++++++++++++++
 tb/tb_vec_ex_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_ex_sequencer.sv
// Lane-serial vector EX sequencer: one shared lane ALU, IDLE/RUN/DONE FSM.
// Define VEC_SAT_EN for signed saturating VADD lanes (default: wrapping).
module vec_ex_sequencer #(
  parameter int LANE_WIDTH    = 16,
  parameter int LANES         = 4,
  parameter int VREG_ID_WIDTH = 5
) (
  input  logic                          I_CLOCK,
  input  logic                          I_RESET_N,
  input  logic                          I_Start,
  input  logic                          I_DE_Valid,
  input  logic [1:0]                    I_VecOp,
  input  logic [LANES*LANE_WIDTH-1:0]   I_VecSrc1Value,
  input  logic [LANES*LANE_WIDTH-1:0]   I_VecSrc2Value,
  input  logic [LANE_WIDTH-1:0]         I_Imm,
  input  logic [1:0]                    I_Idx,
  input  logic [VREG_ID_WIDTH-1:0]      I_DestVRegIdx,
  input  logic                          I_Flush,
  input  logic                          I_GPUStallSignal,
  output logic                          O_Busy,
  output logic [LANES*LANE_WIDTH-1:0]   O_VecDestValue,
  output logic [VREG_ID_WIDTH-1:0]      O_DestVRegIdx,
  output logic                          O_VRegWEn
);

  localparam int VW  = LANES * LANE_WIDTH;
  localparam int CW  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int MSB = LANE_WIDTH - 1;
  localparam logic [CW-1:0] LAST = CW'(LANES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {VADD, VMOV, VMOVI, VCOMPMOV} op_t;

  state_t                  state;
  op_t                     op_q;
  logic [CW-1:0]           cnt;
  logic [VW-1:0]           src1_q;
  logic [VW-1:0]           src2_q;
  logic [VW-1:0]           acc;
  logic [LANE_WIDTH-1:0]   imm_q;
  logic [1:0]              idx_q;

  logic [LANE_WIDTH-1:0]   lane_a;
  logic [LANE_WIDTH-1:0]   lane_b;
  logic [LANE_WIDTH-1:0]   add_res;
  logic [LANE_WIDTH-1:0]   lane_res;
  logic [VW-1:0]           acc_nx;
  logic [VW-1:0]           cmp_val;

  always_comb begin
    lane_a = '0;
    lane_b = '0;
    for (int i = 0; i < LANES; i++) begin
      if (cnt == CW'(i)) begin
        lane_a = src1_q[i*LANE_WIDTH +: LANE_WIDTH];
        lane_b = src2_q[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

`ifdef VEC_SAT_EN
  logic [LANE_WIDTH-1:0] sum;
  logic                  ovf;

  // Overflow only when both operands share a sign the sum lost.
  always_comb begin
    sum     = lane_a + lane_b;
    ovf     = (lane_a[MSB] == lane_b[MSB]) && (sum[MSB] != lane_a[MSB]);
    add_res = ovf ? {lane_a[MSB], {(LANE_WIDTH-1){~lane_a[MSB]}}} : sum;
  end
`else
  always_comb begin
    add_res = lane_a + lane_b;
  end
`endif

  always_comb begin
    lane_res = lane_a;
    unique case (op_q)
      VADD:     lane_res = add_res;
      VMOV:     lane_res = lane_a;
      VMOVI:    lane_res = imm_q;
      VCOMPMOV: lane_res = lane_a;
      default:  lane_res = lane_a;
    endcase
  end

  always_comb begin
    acc_nx  = acc;
    cmp_val = src1_q;
    for (int i = 0; i < LANES; i++) begin
      if (cnt == CW'(i))
        acc_nx[i*LANE_WIDTH +: LANE_WIDTH] = lane_res;
      if (int'(idx_q) == i)
        cmp_val[i*LANE_WIDTH +: LANE_WIDTH] = imm_q;
    end
  end

  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state          <= IDLE;
      op_q           <= VADD;
      cnt            <= '0;
      src1_q         <= '0;
      src2_q         <= '0;
      acc            <= '0;
      imm_q          <= '0;
      idx_q          <= '0;
      O_Busy         <= 1'b0;
      O_VecDestValue <= '0;
      O_DestVRegIdx  <= '0;
      O_VRegWEn      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (I_Start && I_DE_Valid && !I_Flush) begin
            state         <= RUN;
            op_q          <= op_t'(I_VecOp);
            cnt           <= '0;
            src1_q        <= I_VecSrc1Value;
            src2_q        <= I_VecSrc2Value;
            imm_q         <= I_Imm;
            idx_q         <= I_Idx;
            O_DestVRegIdx <= I_DestVRegIdx;
            O_Busy        <= 1'b1;
          end
        end
        RUN: begin
          if (I_Flush) begin
            state  <= IDLE;
            O_Busy <= 1'b0;
          end else if (!I_GPUStallSignal) begin
            if (op_q == VCOMPMOV) begin
              state          <= DONE;
              O_VecDestValue <= cmp_val;
              O_VRegWEn      <= 1'b1;
            end else begin
              acc <= acc_nx;
              cnt <= cnt + 1'b1;
              if (cnt == LAST) begin
                state          <= DONE;
                O_VecDestValue <= acc_nx;
                O_VRegWEn      <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          if (!I_GPUStallSignal) begin
            state     <= IDLE;
            O_VRegWEn <= 1'b0;
            O_Busy    <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          O_VRegWEn <= 1'b0;
          O_Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_ex_sequencer.sv
// Bench for vec_ex_sequencer: directed latency/flush/stall/reset cases
// plus randomized traffic against a whole-vector countdown model.
module tb_vec_ex_sequencer;

  localparam int LW = 16;
  localparam int NL = 4;
  localparam int VW = 64;
  localparam int IW = 5;

  logic          I_CLOCK = 1'b0;
  logic          I_RESET_N = 1'b1;
  logic          I_Start = 1'b0;
  logic          I_DE_Valid = 1'b0;
  logic [1:0]    I_VecOp = '0;
  logic [VW-1:0] I_VecSrc1Value = '0;
  logic [VW-1:0] I_VecSrc2Value = '0;
  logic [LW-1:0] I_Imm = '0;
  logic [1:0]    I_Idx = '0;
  logic [IW-1:0] I_DestVRegIdx = '0;
  logic          I_Flush = 1'b0;
  logic          I_GPUStallSignal = 1'b0;
  logic          O_Busy;
  logic [VW-1:0] O_VecDestValue;
  logic [IW-1:0] O_DestVRegIdx;
  logic          O_VRegWEn;

  vec_ex_sequencer #(
    .LANE_WIDTH(LW), .LANES(NL), .VREG_ID_WIDTH(IW)
  ) dut (
    .I_CLOCK(I_CLOCK),
    .I_RESET_N(I_RESET_N),
    .I_Start(I_Start),
    .I_DE_Valid(I_DE_Valid),
    .I_VecOp(I_VecOp),
    .I_VecSrc1Value(I_VecSrc1Value),
    .I_VecSrc2Value(I_VecSrc2Value),
    .I_Imm(I_Imm),
    .I_Idx(I_Idx),
    .I_DestVRegIdx(I_DestVRegIdx),
    .I_Flush(I_Flush),
    .I_GPUStallSignal(I_GPUStallSignal),
    .O_Busy(O_Busy),
    .O_VecDestValue(O_VecDestValue),
    .O_DestVRegIdx(O_DestVRegIdx),
    .O_VRegWEn(O_VRegWEn)
  );

  initial forever #5 I_CLOCK = ~I_CLOCK;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_result(
    input logic [1:0] op, input logic [63:0] s1, input logic [63:0] s2,
    input logic [15:0] imm, input logic [1:0] idx);
    logic [63:0] r;
    int a, b, s;
    r = '0;
    for (int i = 0; i < NL; i++) begin
      a = int'(s1[i*LW +: LW]);
      b = int'(s2[i*LW +: LW]);
      case (op)
        2'd0: begin
`ifdef VEC_SAT_EN
          if (a > 32767) a = a - 65536;
          if (b > 32767) b = b - 65536;
          s = a + b;
          if (s > 32767) s = 32767;
          if (s < -32768) s = -32768;
          r[i*LW +: LW] = 16'(s);
`else
          s = (a + b) % 65536;
          r[i*LW +: LW] = 16'(s);
`endif
        end
        2'd1: r[i*LW +: LW] = s1[i*LW +: LW];
        2'd2: r[i*LW +: LW] = imm;
        default: r[i*LW +: LW] = (int'(idx) == i) ? imm : s1[i*LW +: LW];
      endcase
    end
    return r;
  endfunction

  // Model: result computed whole at accept, then a cycle countdown.
  logic          m_busy = 1'b0;
  logic          m_run = 1'b0;
  logic          m_wen = 1'b0;
  logic [63:0]   m_val = '0;
  logic [63:0]   m_pend = '0;
  logic [IW-1:0] m_dest = '0;
  int            m_rem = 0;

  always @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      m_busy = 1'b0; m_run = 1'b0; m_wen = 1'b0;
      m_val = '0; m_dest = '0; m_rem = 0;
    end else if (!m_busy) begin
      if (I_Start && I_DE_Valid && !I_Flush) begin
        m_pend = ref_result(I_VecOp, I_VecSrc1Value, I_VecSrc2Value,
                            I_Imm, I_Idx);
        m_rem  = (I_VecOp == 2'd3) ? 1 : NL;
        m_dest = I_DestVRegIdx;
        m_busy = 1'b1;
        m_run  = 1'b1;
      end
    end else if (m_run) begin
      if (I_Flush) begin
        m_busy = 1'b0;
        m_run  = 1'b0;
      end else if (!I_GPUStallSignal) begin
        m_rem--;
        if (m_rem == 0) begin
          m_run = 1'b0;
          m_wen = 1'b1;
          m_val = m_pend;
        end
      end
    end else if (!I_GPUStallSignal) begin
      m_busy = 1'b0;
      m_wen  = 1'b0;
    end
  end

  always @(posedge I_CLOCK) begin
    chk("model busy", 64'(O_Busy), 64'(m_busy));
    chk("model wen", 64'(O_VRegWEn), 64'(m_wen));
    if (m_wen) begin
      chk("model value", O_VecDestValue, m_val);
      chk("model dest", 64'(O_DestVRegIdx), 64'(m_dest));
    end
  end

  task automatic issue(input logic [1:0] op, input logic [63:0] s1,
                       input logic [63:0] s2, input logic [15:0] imm,
                       input logic [1:0] idx, input logic [IW-1:0] dest);
    @(posedge I_CLOCK);
    I_Start = 1'b1; I_DE_Valid = 1'b1; I_VecOp = op;
    I_VecSrc1Value = s1; I_VecSrc2Value = s2;
    I_Imm = imm; I_Idx = idx; I_DestVRegIdx = dest;
    @(posedge I_CLOCK);
    I_Start = 1'b0; I_DE_Valid = 1'b0;
  endtask

  task automatic run_op(input string nm, input logic [1:0] op,
                        input logic [63:0] s1, input logic [63:0] s2,
                        input logic [15:0] imm, input logic [1:0] idx,
                        input logic [IW-1:0] dest, input logic [63:0] exp,
                        input int lat);
    issue(op, s1, s2, imm, idx, dest);
    chk({nm, " busy@k"}, 64'(O_Busy), 64'd1);
    for (int j = 1; j < lat; j++) begin
      @(posedge I_CLOCK);
      chk({nm, " early wen"}, 64'(O_VRegWEn), 64'd0);
      chk({nm, " busy run"}, 64'(O_Busy), 64'd1);
    end
    @(posedge I_CLOCK);
    chk({nm, " wen"}, 64'(O_VRegWEn), 64'd1);
    chk({nm, " value"}, O_VecDestValue, exp);
    chk({nm, " dest"}, 64'(O_DestVRegIdx), 64'(dest));
    chk({nm, " busy done"}, 64'(O_Busy), 64'd1);
    @(posedge I_CLOCK);
    chk({nm, " wen off"}, 64'(O_VRegWEn), 64'd0);
    chk({nm, " busy off"}, 64'(O_Busy), 64'd0);
  endtask

  function automatic logic [15:0] rnd_lane();
    case ($urandom_range(0, 7))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [63:0] rnd_vec();
    return {rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()};
  endfunction

  logic [63:0] sat_exp;

  initial begin
`ifdef VEC_SAT_EN
    sat_exp = 64'h0000_0000_8000_7FFF;
`else
    sat_exp = 64'h0000_0000_7FFF_8000;
`endif
    #1 I_RESET_N = 1'b0;
    #1;
    chk("reset busy", 64'(O_Busy), 64'd0);
    chk("reset wen", 64'(O_VRegWEn), 64'd0);
    chk("reset value", O_VecDestValue, 64'd0);
    chk("reset dest", 64'(O_DestVRegIdx), 64'd0);
    #10 I_RESET_N = 1'b1;

    run_op("vadd", 2'd0, 64'h0004_0003_0002_0001, 64'h0001_0001_0001_0001,
           16'h0, 2'd0, 5'd3, 64'h0005_0004_0003_0002, NL);
    run_op("vcompmov", 2'd3, 64'h1111_2222_3333_4444, 64'h0,
           16'hABCD, 2'd2, 5'd7, 64'h1111_ABCD_3333_4444, 1);
    run_op("vadd sat", 2'd0, 64'h0000_0000_8000_7FFF,
           64'h0000_0000_FFFF_0001, 16'h0, 2'd0, 5'd9, sat_exp, NL);
    run_op("vmovi", 2'd2, 64'h0, 64'h0, 16'h5A5A, 2'd0, 5'd1,
           64'h5A5A_5A5A_5A5A_5A5A, NL);

    // Flush mid-RUN on edge k+2
    issue(2'd2, 64'h0, 64'h0, 16'h00FF, 2'd0, 5'd4);
    @(posedge I_CLOCK);
    chk("flush busy k+1", 64'(O_Busy), 64'd1);
    I_Flush = 1'b1;
    @(posedge I_CLOCK);
    I_Flush = 1'b0;
    chk("flush busy k+2", 64'(O_Busy), 64'd0);
    chk("flush wen k+2", 64'(O_VRegWEn), 64'd0);
    repeat (5) begin
      @(posedge I_CLOCK);
      chk("flush no wen", 64'(O_VRegWEn), 64'd0);
    end

    // Stall three cycles in DONE; start and flush there are ignored
    issue(2'd1, 64'hDEAD_BEEF_1234_5678, 64'h0, 16'h0, 2'd0, 5'd17);
    repeat (NL) @(posedge I_CLOCK);
    chk("stall wen k+4", 64'(O_VRegWEn), 64'd1);
    I_GPUStallSignal = 1'b1;
    I_Start = 1'b1; I_DE_Valid = 1'b1; I_Flush = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(posedge I_CLOCK);
      chk("stall wen held", 64'(O_VRegWEn), 64'd1);
      chk("stall value held", O_VecDestValue, 64'hDEAD_BEEF_1234_5678);
    end
    I_GPUStallSignal = 1'b0;
    I_Start = 1'b0; I_DE_Valid = 1'b0; I_Flush = 1'b0;
    @(posedge I_CLOCK);
    chk("stall release wen", 64'(O_VRegWEn), 64'd0);
    chk("stall release busy", 64'(O_Busy), 64'd0);

    // Asynchronous reset mid-RUN
    issue(2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 16'h0, 2'd0, 5'd21);
    repeat (2) @(posedge I_CLOCK);
    #2 I_RESET_N = 1'b0;
    #1;
    chk("midrun rst busy", 64'(O_Busy), 64'd0);
    chk("midrun rst wen", 64'(O_VRegWEn), 64'd0);
    chk("midrun rst value", O_VecDestValue, 64'd0);
    chk("midrun rst dest", 64'(O_DestVRegIdx), 64'd0);
    @(posedge I_CLOCK);
    #2 I_RESET_N = 1'b1;
    run_op("vadd post rst", 2'd0, 64'h0004_0003_0002_0001,
           64'h0001_0001_0001_0001, 16'h0, 2'd0, 5'd12,
           64'h0005_0004_0003_0002, NL);

    for (int c = 0; c < 600; c++) begin
      @(posedge I_CLOCK);
      I_Start          = ($urandom_range(0, 1) == 1);
      I_DE_Valid       = ($urandom_range(0, 3) != 0);
      I_VecOp          = 2'($urandom_range(0, 3));
      I_VecSrc1Value   = rnd_vec();
      I_VecSrc2Value   = rnd_vec();
      I_Imm            = rnd_lane();
      I_Idx            = 2'($urandom_range(0, 3));
      I_DestVRegIdx    = 5'($urandom);
      I_Flush          = ($urandom_range(0, 11) == 0);
      I_GPUStallSignal = ($urandom_range(0, 3) == 0);
    end
    @(posedge I_CLOCK);
    I_Start = 1'b0; I_DE_Valid = 1'b0;
    I_Flush = 1'b0; I_GPUStallSignal = 1'b0;
    repeat (NL + 4) @(posedge I_CLOCK);
    chk("drain busy", 64'(O_Busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
